// File: rtl/dds_env_pkg.sv
// dds_env_pkg: shared envelope state type, default widths and level constants
package dds_env_pkg;
   localparam int SAMPLE_W_D = 16;
   localparam int ENV_W_D = 12;
   localparam int RATE_W_D = 8;
   localparam logic [ENV_W_D-1:0] ENV_MAX = 12'hFFF;
   localparam logic [SAMPLE_W_D-1:0] MIDSCALE = 16'h8000;
   typedef enum logic [2:0] {S_IDLE, S_ATTACK, S_DECAY, S_SUSTAIN, S_RELEASE} env_state_t;
endpackage

// File: rtl/env_scale.sv
// env_scale: two-stage scaling of an offset-binary sample about midscale by the envelope gain
module env_scale
   import dds_env_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_D,
   parameter int ENV_W = ENV_W_D
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic [ENV_W-1:0]    env,
   input  logic                env_bypass,
   output logic [SAMPLE_W-1:0] sample_out
);
   localparam logic [SAMPLE_W-1:0] L_MID = {1'b1, {(SAMPLE_W-1){1'b0}}};
   logic signed [SAMPLE_W:0] r_d, w_d;
   logic [ENV_W:0] r_g, w_g;
   logic signed [SAMPLE_W+ENV_W+2:0] w_p;
   // full-scale env maps to exact unity so the top code passes through unchanged
   always_comb begin
      w_d = $signed({1'b0, sample_in}) - $signed({1'b0, L_MID});
      w_g = (env_bypass || &env) ? {1'b1, {ENV_W{1'b0}}} : {1'b0, env};
      w_p = r_d * $signed({1'b0, r_g});
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_d <= '0;
         r_g <= '0;
         sample_out <= L_MID;
      end else begin
         r_d <= w_d;
         r_g <= w_g;
         sample_out <= SAMPLE_W'(w_p >>> ENV_W) + L_MID;
      end
   end
endmodule

// File: rtl/adsr_env.sv
// adsr_env: tick-stepped ADSR envelope FSM with prescaler, driving the sample scaler
module adsr_env
   import dds_env_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_D,
   parameter int ENV_W = ENV_W_D,
   parameter int RATE_W = RATE_W_D
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick,
   input  logic                gate,
   input  logic [RATE_W-1:0]   attack_rate,
   input  logic [RATE_W-1:0]   decay_rate,
   input  logic [RATE_W-1:0]   release_rate,
   input  logic [ENV_W-1:0]    sustain_level,
   input  logic                env_bypass,
   input  logic [SAMPLE_W-1:0] sample_in,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic [ENV_W-1:0]    env_level,
   output logic                busy
);
   localparam logic [ENV_W-1:0] L_MAX = '1;
   localparam logic [ENV_W-1:0] L_MAX_M1 = L_MAX - 1'b1;
   localparam logic [ENV_W-1:0] L_ONE = {{(ENV_W-1){1'b0}}, 1'b1};
   env_state_t r_state;
   logic [ENV_W-1:0] r_env;
   logic [RATE_W-1:0] r_pre, w_rate;
   logic r_busy, w_step;
   always_comb begin
      w_rate = r_state == S_ATTACK ? attack_rate :
               r_state == S_DECAY ? decay_rate :
               r_state == S_RELEASE ? release_rate : '0;
      w_step = r_pre >= w_rate;
   end
   // later r_pre writes in a branch win: every state change restarts the prescaler
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_env <= '0;
         r_pre <= '0;
         r_busy <= 1'b0;
      end else if (tick) begin
         r_pre <= w_step ? '0 : r_pre + 1'b1;
         case (r_state)
            S_IDLE: if (gate) begin
               r_state <= S_ATTACK;
               r_pre <= '0;
               r_busy <= 1'b1;
            end
            S_ATTACK: if (!gate) begin
               r_state <= S_RELEASE;
               r_pre <= '0;
            end else if (r_env == L_MAX) begin
               r_state <= S_DECAY;
               r_pre <= '0;
            end else if (w_step) begin
               r_env <= r_env + 1'b1;
               if (r_env == L_MAX_M1) r_state <= S_DECAY;
            end
            S_DECAY: if (!gate) begin
               r_state <= S_RELEASE;
               r_pre <= '0;
            end else if (r_env <= sustain_level) begin
               r_state <= S_SUSTAIN;
               r_pre <= '0;
            end else if (w_step) r_env <= r_env - 1'b1;
            S_SUSTAIN: if (!gate) begin
               r_state <= S_RELEASE;
               r_pre <= '0;
            end else if (sustain_level < r_env) begin
               r_state <= S_DECAY;
               r_pre <= '0;
            end
            S_RELEASE: if (gate) begin
               r_state <= S_ATTACK;
               r_pre <= '0;
            end else if (r_env == '0) begin
               r_state <= S_IDLE;
               r_pre <= '0;
               r_busy <= 1'b0;
            end else if (w_step) begin
               r_env <= r_env - 1'b1;
               if (r_env == L_ONE) begin
                  r_state <= S_IDLE;
                  r_busy <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign env_level = r_env;
   assign busy = r_busy;
   env_scale #(.SAMPLE_W(SAMPLE_W), .ENV_W(ENV_W)) u_scale (
      .clk(clk),
      .rst_n(rst_n),
      .sample_in(sample_in),
      .env(r_env),
      .env_bypass(env_bypass),
      .sample_out(sample_out)
   );
endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env: directed-step bench for the ADSR envelope and its sample scaling
module tb_adsr_env;
   import dds_env_pkg::*;
   logic clk = 1'b0;
   logic rst_n, tick, gate, env_bypass;
   logic [7:0] attack_rate, decay_rate, release_rate;
   logic [11:0] sustain_level, env_level;
   logic [15:0] sample_in, sample_out;
   logic busy;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   adsr_env dut (
      .clk(clk),
      .rst_n(rst_n),
      .tick(tick),
      .gate(gate),
      .attack_rate(attack_rate),
      .decay_rate(decay_rate),
      .release_rate(release_rate),
      .sustain_level(sustain_level),
      .env_bypass(env_bypass),
      .sample_in(sample_in),
      .sample_out(sample_out),
      .env_level(env_level),
      .busy(busy)
   );
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      rst_n = 1'b0; tick = 1'b1; gate = 1'b1; env_bypass = 1'b0;
      attack_rate = 8'd0; decay_rate = 8'd1; release_rate = 8'd0;
      sustain_level = 12'd2048; sample_in = 16'hC000;
      cyc(3);
      chk("rst_out", 32'(sample_out), 32'(MIDSCALE));
      chk("rst_env", 32'(env_level), 0);
      chk("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      cyc(1);
      chk("atk_enter_busy", 32'(busy), 1);
      chk("atk_enter_env", 32'(env_level), 0);
      cyc(4094);
      chk("atk_4094", 32'(env_level), 4094);
      cyc(1);
      chk("atk_max", 32'(env_level), 32'(ENV_MAX));
      cyc(4093);
      chk("dec_2049", 32'(env_level), 2049);
      cyc(1);
      chk("dec_2048", 32'(env_level), 2048);
      cyc(10);
      chk("sus_hold", 32'(env_level), 2048);
      chk("scale_c000", 32'(sample_out), 32'h0000A000);
      sample_in = 16'h0000;
      cyc(1);
      chk("scale_latency", 32'(sample_out), 32'h0000A000);
      cyc(1);
      chk("scale_0000", 32'(sample_out), 32'h00004000);
      sample_in = 16'h7FFF;
      cyc(2);
      chk("scale_floor", 32'(sample_out), 32'h00007FFF);
      env_bypass = 1'b1; sample_in = 16'h1234;
      cyc(2);
      chk("bypass", 32'(sample_out), 32'h00001234);
      env_bypass = 1'b0; sample_in = 16'hC000;
      cyc(2);
      chk("bypass_off", 32'(sample_out), 32'h0000A000);
      gate = 1'b0;
      cyc(1);
      chk("rel_enter", 32'(env_level), 2048);
      cyc(1048);
      chk("rel_1000", 32'(env_level), 1000);
      gate = 1'b1;
      cyc(1);
      chk("retrig_hold", 32'(env_level), 1000);
      cyc(1);
      chk("retrig_1001", 32'(env_level), 1001);
      cyc(3094);
      chk("retrig_max", 32'(env_level), 4095);
      cyc(4093);
      chk("dec2_2049", 32'(env_level), 2049);
      cyc(1);
      chk("dec2_2048", 32'(env_level), 2048);
      cyc(2);
      sustain_level = 12'd100;
      cyc(1);
      chk("sus_low_enter", 32'(env_level), 2048);
      cyc(3895);
      chk("sus_low_101", 32'(env_level), 101);
      cyc(1);
      chk("sus_low_100", 32'(env_level), 100);
      cyc(1);
      sustain_level = 12'd2048;
      cyc(10);
      chk("sus_raise_ignored", 32'(env_level), 100);
      gate = 1'b0; release_rate = 8'd200;
      cyc(51);
      chk("rate200_hold", 32'(env_level), 100);
      release_rate = 8'd0;
      cyc(1);
      chk("rate_drop_step", 32'(env_level), 99);
      tick = 1'b0;
      cyc(1000);
      chk("freeze_env", 32'(env_level), 99);
      chk("freeze_busy", 32'(busy), 1);
      tick = 1'b1;
      cyc(98);
      chk("rel_1", 32'(env_level), 1);
      chk("rel_1_busy", 32'(busy), 1);
      cyc(1);
      chk("idle_env", 32'(env_level), 0);
      chk("idle_busy", 32'(busy), 0);
      cyc(5);
      chk("idle_sat", 32'(env_level), 0);
      chk("scale_env0", 32'(sample_out), 32'(MIDSCALE));
      sustain_level = 12'd4095; gate = 1'b1;
      cyc(1);
      chk("atk2_busy", 32'(busy), 1);
      cyc(4095);
      chk("atk2_max", 32'(env_level), 4095);
      cyc(6);
      chk("sus_max_hold", 32'(env_level), 4095);
      sample_in = 16'hFFFF;
      cyc(2);
      chk("scale_ffff", 32'(sample_out), 32'h0000FFFF);
      sample_in = 16'h0000;
      cyc(2);
      chk("scale_min", 32'(sample_out), 0);
      rst_n = 1'b0;
      cyc(1);
      chk("midrst_out", 32'(sample_out), 32'h00008000);
      chk("midrst_env", 32'(env_level), 0);
      chk("midrst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/adsr_env.md
# adsr_env

Per-voice-mix amplitude envelope (Attack/Decay/Sustain/Release) placed between the modulation mixer output and the DAC SPI serializer. It takes the 16-bit offset-binary mixed sample and scales it about midscale by a 12-bit envelope. The envelope is driven by a gate and four rate/level controls from the command decoder, and is stepped on the divided-clock tick.

## Interface
Parameters:
- SAMPLE_W, 16, sample width (offset binary, midscale 2^(SAMPLE_W-1))
- ENV_W, 12, envelope level width
- RATE_W, 8, prescaler/rate field width

Ports:
- clk  in  1  system clock; only clock
- rst_n  in  1  synchronous, active-low reset
- tick  in  1  one-clk strobe; the FSM advances only on tick cycles
- gate  in  1  note on (1) / off (0), level-sensitive
- attack_rate  in  RATE_W  ticks per step = rate+1
- decay_rate  in  RATE_W  ticks per step = rate+1
- release_rate  in  RATE_W  ticks per step = rate+1
- sustain_level  in  ENV_W  sustain target level
- env_bypass  in  1  forces gain to unity; the FSM still runs
- sample_in  in  SAMPLE_W  mixer sample
- sample_out  out  SAMPLE_W  scaled sample to the DAC serializer
- env_level  out  ENV_W  current envelope value
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Transitions and env steps occur only on clk edges where tick=1.
- Prescaler `pre` (RATE_W bits) serves the active rate r. On tick:
  - if pre >= r: step env by 1, pre <= 0
  - else: pre <= pre+1
  - The >= comparison means a rate lowered mid-count steps on the next tick.
  - pre clears on every state change.
- IDLE: env=0. gate=1 -> ATTACK.
- ATTACK: env +1 per step. When env reaches ENV_MAX (4095) -> DECAY. gate=0 -> RELEASE.
- DECAY: if env <= sustain_level -> SUSTAIN, with no step that tick. Otherwise env -1 per step. gate=0 -> RELEASE.
- SUSTAIN: env held. If sustain_level < env -> DECAY. A raised sustain_level is ignored. gate=0 -> RELEASE.
- RELEASE: env -1 per step. When env reaches 0 -> IDLE. gate=1 -> ATTACK from the current env, with no reset to 0.
- gate takes priority over the level-reached checks on the same tick.
- env never wraps: it saturates at 0 and ENV_MAX.
- Gain g is ENV_W+1 bits:
  - g = 2^ENV_W if env_bypass=1 or env = ENV_MAX
  - otherwise g = env
- Scaling: d = sample_in - MIDSCALE, a signed SAMPLE_W+1 value. p = d*g is signed. sample_out = MIDSCALE + (p >>> ENV_W), an arithmetic shift truncating toward -inf. The result always fits in SAMPLE_W bits, so no clipping is needed.

## Timing
- Reset (rst_n=0 at a clk edge): state=IDLE, env=0, pre=0, pipeline registers cleared, sample_out=MIDSCALE (0x8000), env_level=0, busy=0. Reset overrides tick and gate.
- Reset asserted mid-note: next cycle the outputs are midscale/0 with no release tail.
- FSM latency: gate change -> state change at the first tick edge after gate settles. busy/env_level are registered and reflect that edge.
- Data path: 2-cycle pipeline.
  - Stage 1 registers d and g.
  - Stage 2 registers sample_out.
  - sample_out(n+2) = f(sample_in(n), env(n)), independent of tick.
- Minimum step interval is one tick (rate=0). Full attack 0->4095 at rate r takes 4095*(r+1) ticks.

## Structure
- Package `dds_env_pkg`: state enum `env_state_t`, constants ENV_MAX, MIDSCALE, default widths.
- Sub-module `env_scale`: the 2-stage subtract/multiply/shift/add pipeline. It takes (sample_in, env, env_bypass) and produces sample_out.
- Top `adsr_env` holds the FSM, the prescaler and the env register.

## Test plan
- Reset: rst_n=0 with gate=1 and tick every clk -> sample_out=0x8000, env_level=0, busy=0. After release, ATTACK is entered on the first tick edge.
- Attack/decay: attack_rate=0, decay_rate=1, sustain=2048, gate=1, tick every clk -> env reaches 4095 after 4095 ticks, then 2048 after 2047*2 more ticks. State SUSTAIN holds at 2048.
- Release and retrigger: from SUSTAIN at 2048, gate=0 with release_rate=0 -> env 1000 after 1048 ticks. gate=1 at that point -> ATTACK continues from 1000 (next step 1001), not from 0.
- Scaling: env=2048 with sample_in=0xC000 -> 0xA000 two clks later. env=4095 with 0xFFFF -> 0xFFFF. env=4095 with 0x0000 -> 0x0000. env=0 -> 0x8000. env_bypass=1 passes sample_in exactly.
- Boundaries:
  - sustain=4095 -> DECAY exits to SUSTAIN on its first tick.
  - sustain lowered from 2048 to 100 in SUSTAIN -> DECAY, ending at 100.
  - rate changed 200->0 with pre=50 -> step on the next tick.
  - tick=0 for 1000 clks -> env and state frozen.
